// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/prefetch slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int          FETCH_XLEN     = 32;
    localparam int          FETCH_ILEN     = 32;
    localparam int          FETCH_DEPTH    = 4;
    localparam int          FETCH_PC_STEP  = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // One prefetch queue entry at the default widths.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] instr;
    } fetch_entry_t;

    // Saturating 32-bit add used by the optional event counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push, pop, flush, occupancy count, full and empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push while full without popping; pop on empty is ignored.
//
// Ports: clk/rst, push+push_dat, pop, flush (clears everything, wins over push/pop),
//        head_dat (zero when empty), count, full, empty.
module fetch_queue #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          pop_ok;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign pop_ok   = pop & ~empty;
    assign count    = cnt;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// PC owner + sequential instruction fetch into a DEPTH-entry prefetch queue drained by decode.
// Latency: request in cycle N, queued end of N+1, out_valid in N+2; 1 instr/cycle steady state.
// Backpressure: requests stop once queued + in-flight entries would fill the queue; out_ready stalls the head.
//
// Ports: clk, rst (async active-high), fetch_en, redirect_valid/redirect_pc,
//        imem_req/imem_addr/imem_rdata (1-cycle synchronous memory), out_valid/out_instr/out_pc/out_ready.
// Build option FETCH_PERF_EN adds perf_delivered and perf_flushed (32-bit, saturating).
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = FETCH_XLEN,
    parameter int               ILEN     = FETCH_ILEN,
    parameter int               DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(FETCH_RESET_PC),
    parameter int               PC_STEP  = FETCH_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_delivered,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;

    entry_t          push_entry;
    entry_t          head_entry;
    logic [AW:0]     q_count;
    logic            q_full;
    logic            q_empty;

    logic            pop;
    logic            push;
    logic            issue;
    logic [AW+1:0]   occupancy;

    assign out_valid = ~q_empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;

    // Credit: entries that will still be queued after this cycle's pop, plus the
    // response already on its way, must leave room for one more response.
    assign occupancy = {1'b0, q_count} - (AW+2)'(pop) + (AW+2)'(inflight);
    assign issue     = fetch_en & ~redirect_valid & ~rst & (occupancy < (AW+2)'(DEPTH));

    // The full term never blocks a legal push; it only guards against a lost entry.
    assign push      = inflight & ~redirect_valid & (~q_full | pop);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = imem_rdata;

    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            // Any response arriving now belongs to the old path and is dropped.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_queue #(
        .DW    (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head_entry),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_delivered <= '0;
            perf_flushed   <= '0;
        end else if (redirect_valid) begin
            perf_flushed <= sat_add32(perf_flushed, 32'(q_count) + 32'(inflight));
        end else if (pop) begin
            perf_delivered <= sat_add32(perf_delivered, 32'd1);
        end
    end
`endif

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the basic fetch stage. It owns the PC, issues sequential requests to a synchronous 1-cycle-latency instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. The queue is drained by decode through a valid/ready handshake. A redirect (jump/branch) flushes both the queue and any in-flight fetch, then restarts fetching at the target.

Parameters:
XLEN, 32, PC/address width
ILEN, 32, instruction width
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, PC fetched first after reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  permits new memory requests
redirect_valid  in  1  jump/branch taken this cycle
redirect_pc  in  XLEN  redirect target
imem_req  out  1  memory read request
imem_addr  out  XLEN  request address
imem_rdata  in  ILEN  data for the request of the previous cycle
out_valid  out  1  head entry valid to decode
out_instr  out  ILEN  head instruction
out_pc  out  XLEN  PC of head instruction
out_ready  in  1  decode accepts head

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, queue count=0, rd/wr pointers=0, inflight=0. Outputs: imem_req=0, out_valid=0, out_instr=0, out_pc=0.
- pop = out_valid & out_ready.
- issue = fetch_en & ~redirect_valid & ((count - pop + inflight) < DEPTH).
- imem_req = issue; imem_addr = fetch_pc (combinational).
- On issue: fetch_pc <= fetch_pc + PC_STEP, wrapping mod 2^XLEN. inflight <= 1 and inflight_pc <= fetch_pc; otherwise inflight <= 0.
- Response: in the cycle after an issue, if inflight & ~redirect_valid, push {inflight_pc, imem_rdata} into the queue.
- out_valid = (count != 0) & ~redirect_valid. out_instr/out_pc show the head entry, or 0 when the queue is empty.
- Latency: request in cycle N, queued at the end of N+1, out_valid in N+2. Steady-state throughput is 1 instr/cycle with out_ready=1.
- Simultaneous push and pop: count unchanged, both pointers advance (mod DEPTH).
- Full: the credit rule guarantees a push never occurs while full; no request is issued when full.
- Empty: out_valid=0; out_ready is ignored.
- Redirect (highest priority): count<=0, pointers<=0, inflight<=0 (the response arriving this cycle is dropped), fetch_pc<=redirect_pc. No request and no pop in that cycle. The first request to redirect_pc goes out the following cycle.
- fetch_en=0: no new requests; an in-flight response still lands and the queue keeps draining.
- Back-to-back redirects: the last one wins; no request is issued until redirect_valid falls.
- Reset mid-operation: all state is cleared immediately; a pending memory response is ignored because inflight=0.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_delivered (32-bit) and perf_flushed (32-bit), both reset to 0 and saturating at 2^32-1.
- perf_delivered increments on each pop.
- perf_flushed adds count+inflight on each redirect.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: XLEN/ILEN defaults, RESET_PC default, and the fetch_entry_t struct {pc[XLEN], instr[ILEN]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty.
- Credit logic, PC register and the in-flight tracker stay in fetch_prefetch_unit.

Test Plan:
1. Reset, then fetch_en=1, out_ready=1, memory returning instr=addr^32'hA5A5_0000 -> imem_addr 0,4,8,... in consecutive cycles; first out_valid 2 cycles after the first request with out_pc=0; then one entry per cycle, no gaps.
2. out_ready=0 with DEPTH=4 -> exactly 4 requests issued (0..C), imem_req then held 0. Raising out_ready -> entries 0,4,8,C delivered in order, requests resume at 0x10.
3. Redirect to 0x200 while queue holds 3 entries and one is in flight -> out_valid=0 that cycle; next cycle imem_addr=0x200; first delivered out_pc=0x200; none of the stale PCs ever appear.
4. fetch_pc=0xFFFF_FFFC, free-running -> next request address 0x0000_0000 (wrap), no stall.
5. Assert rst mid-stream with inflight=1 -> outputs 0 immediately; after release, first delivered out_pc=RESET_PC and the stale response is not queued.
6. With FETCH_PERF_EN: deliver 5, then redirect with 2 queued + 1 in flight -> perf_delivered=5, perf_flushed=3.
